mul_div_unit: RTL

Iterative RV32M multiply/divide unit. It sits between the register-file read ports and the write-back path. It takes two source operands read from `busA`/`busB` with a funct3 opcode and destination index. It produces a 32-bit result plus `rd` and write-enable, which drive `busW`/`rd`/`RegWr` of the register file. One operation is in flight at a time, and both sides use valid/ready handshakes.

---
 rtl/mul_div_unit_pkg.sv | 19 +
 rtl/mdu_div_core.sv | 43 ++++
 rtl/mul_div_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared opcode and FSM encodings for the iterative RV32M multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring-divider iteration datapath on unsigned magnitudes; one quotient bit per step.
module mdu_div_core
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   partial;
  logic [XLEN-1:0] diff;
  logic            fits;

  // The partial remainder is always below the divisor, so the difference fits in XLEN bits.
  always_comb begin
    partial  = {rem_q, quo_q[XLEN-1]};
    fits     = (partial >= {1'b0, dsr_q});
    diff     = partial[XLEN-1:0] - dsr_q;
    rem_next = fits ? diff : partial[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      quo_q <= quo_next;
      rem_q <= rem_next;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier and restoring divider
// on magnitudes, with sign fix-up applied on the final iteration.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wen_out
);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  mdu_state_t state, state_next;

  logic [4:0]        cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;
  logic [2*XLEN-1:0] prod_next;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN:0]     mul_sum;

  logic              accept, last, calc;
  logic              signed_a, signed_b, a_neg, b_neg, res_neg;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res, final_res;
  logic [XLEN-1:0]   quo_next, rem_next;

  // Accept-time operand decode: magnitudes, result sign and special division cases.
  always_comb begin
    signed_a    = (funct3 != MDU_MULHU) && (funct3 != MDU_DIVU) && (funct3 != MDU_REMU);
    signed_b    = signed_a && (funct3 != MDU_MULHSU);
    a_neg       = signed_a & src1[XLEN-1];
    b_neg       = signed_b & src2[XLEN-1];
    mag_a       = cond_neg(src1, a_neg);
    mag_b       = cond_neg(src2, b_neg);
    res_neg     = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = funct3[2] && (src2 == '0);
    div_ovf     = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
                  (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    special     = div_zero || div_ovf;
    // Overflow quotient equals src1 (most negative value); remainder is zero.
    if (div_zero) special_res = funct3[1] ? src1 : '1;
    else          special_res = funct3[1] ? '0 : src1;
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign wen_out   = out_valid & out_ready & (rd_out != 5'd0);
  assign accept    = in_ready & in_valid;
  assign calc      = (state == ST_CALC);
  assign last      = calc && (cnt == 5'd31);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid) state_next = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == 5'd31) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Iteration datapath: one multiplier bit and one quotient bit per CALC cycle.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {mul_sum, prod_q[XLEN-1:1]};
    prod_fin  = cond_neg_wide(prod_next, neg_q);
    if (op_q[2])              final_res = cond_neg(op_q[1] ? rem_next : quo_next, neg_q);
    else if (op_q == MDU_MUL) final_res = prod_fin[XLEN-1:0];
    else                      final_res = prod_fin[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= funct3;
      neg_q   <= res_neg;
      mcand_q <= mag_a;
      prod_q  <= {{XLEN{1'b0}}, mag_b};
    end else if (calc) begin
      prod_q  <= prod_next;
    end
  end

  mdu_div_core #(.XLEN(XLEN)) u_div_core (
    .clk      (clk),
    .load     (accept),
    .step     (calc),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // Result/index registers: written at accept (special cases) or on the last iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rd_out <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        rd_out <= rd_in;
        if (special) result <= special_res;
      end
      if (calc) cnt <= cnt + 5'd1;
      if (last) result <= final_res;
    end
  end

endmodule
